// File: rtl/roll_sequencer.sv
// Roll sequencer: control block for the LFSR dice datapath.
//
// A roll is a reseed pulse followed by a series of step pulses whose spacing
// grows by 1/8 each step, giving a slowing-down effect. Each stepped value is
// captured for display, and the final value is committed into a small circular
// history that the "previous" button pages back through while idle.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        pulse: begin or restart a roll
//   i_stop         pulse: end the roll at the next boundary
//   i_previous     pulse: show the next-older history entry (idle only)
//   i_value        datapath result, valid in the cycle after o_step
//   o_reseed       pulse: datapath reloads its seed
//   o_step         pulse: datapath advances one step
//   o_busy         high while a roll is in progress
//   o_done         pulse: result committed to history
//   o_display      value to show
//   o_hist_count   number of valid history entries
module roll_sequencer #(
  parameter int unsigned INIT_PERIOD = 1000000,
  parameter int unsigned MAX_STEPS   = 27,
  parameter int unsigned HIST_DEPTH  = 4,
  parameter int unsigned DATA_W      = 13,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic                                i_stop,
  input  logic                                i_previous,
  input  logic [DATA_W-1:0]                   i_value,
  output logic                                o_reseed,
  output logic                                o_step,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [DATA_W-1:0]                   o_display,
  output logic [$clog2(HIST_DEPTH+1)-1:0]     o_hist_count
);

  localparam int unsigned HCW = $clog2(HIST_DEPTH + 1);
  localparam int unsigned PTW = $clog2(HIST_DEPTH);
  localparam int unsigned SW  = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {StIdle, StRun, StStep, StCapture, StCommit} state_e;

  state_e state_q, state_d;

  logic              reseed_q, reseed_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [SW-1:0]     steps_q, steps_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic [HCW-1:0]    view_q, view_d;
  logic [HCW-1:0]    count_q, count_d;
  logic [PTW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] hist_q [HIST_DEPTH];
  logic              hist_we;

  logic              in_roll;
  logic              stop_eff;
  logic              tick_last;
  logic [CNT_W:0]    period_sum;
  logic [CNT_W-1:0]  period_grow;
  logic [HCW:0]      view_inc;
  logic              view_ok;
  logic [PTW:0]      rd_sum;
  logic [PTW-1:0]    rd_idx;

  assign in_roll   = (state_q == StRun) || (state_q == StStep) || (state_q == StCapture);
  // A stop arriving in the boundary cycle itself still suppresses the next step.
  assign stop_eff  = stop_q | i_stop;
  assign tick_last = (tick_q == period_q - CNT_W'(1));

  assign period_sum  = {1'b0, period_q} + {1'b0, (period_q >> 3)};
  assign period_grow = period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];

  assign view_inc = {1'b0, view_q} + (HCW + 1)'(1);
  assign view_ok  = (view_inc < {1'b0, count_q});

  // Physical slot of the entry at age view_q+1; wr_ptr_q points past the newest.
  assign rd_sum = (PTW + 1)'(wr_ptr_q) + (PTW + 1)'(HIST_DEPTH - 2) - (PTW + 1)'(view_q);
  assign rd_idx = (rd_sum >= (PTW + 1)'(HIST_DEPTH)) ? PTW'(rd_sum - (PTW + 1)'(HIST_DEPTH))
                                                     : PTW'(rd_sum);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start pulse always (re)enters RUN, even from COMMIT.
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StRun:     if (tick_last) state_d = stop_eff ? StCommit : StStep;
        StStep:    state_d = StCapture;
        StCapture: state_d = ((steps_q == SW'(1)) || stop_eff) ? StCommit : StRun;
        StCommit:  state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Output logic: pulses are decoded from the state being entered and registered.
  always_comb begin
    reseed_d = i_start;
    step_d   = (state_d == StStep);
    done_d   = (state_d == StCommit);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reseed_q <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      reseed_q <= reseed_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Datapath next-state
  always_comb begin
    tick_d    = '0;
    period_d  = period_q;
    steps_d   = steps_q;
    stop_d    = stop_q;
    display_d = display_q;
    view_d    = view_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    hist_we   = 1'b0;

    if ((state_q == StRun) && !i_start) begin
      tick_d = tick_q + CNT_W'(1);
    end

    // Commit always completes, even when a start arrives in the same cycle.
    if (state_q == StCommit) begin
      hist_we  = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTW'(HIST_DEPTH - 1)) ? '0 : wr_ptr_q + PTW'(1);
      if (count_q != HCW'(HIST_DEPTH)) begin
        count_d = count_q + HCW'(1);
      end
      view_d = '0;
    end

    if (i_start) begin
      period_d = CNT_W'(INIT_PERIOD);
      steps_d  = SW'(MAX_STEPS);
      stop_d   = 1'b0;
    end else begin
      if (in_roll && i_stop) begin
        stop_d = 1'b1;
      end
      if (state_q == StCapture) begin
        display_d = i_value;
        steps_d   = steps_q - SW'(1);
        period_d  = period_grow;
      end
      if ((state_q == StIdle) && i_previous && view_ok) begin
        view_d    = view_inc[HCW-1:0];
        display_d = hist_q[rd_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_q  <= '0;
      tick_q    <= '0;
      steps_q   <= '0;
      stop_q    <= 1'b0;
      display_q <= '0;
      view_q    <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
    end else begin
      period_q  <= period_d;
      tick_q    <= tick_d;
      steps_q   <= steps_d;
      stop_q    <= stop_d;
      display_q <= display_d;
      view_q    <= view_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // History storage; validity is tracked by count_q, so entries need no reset.
  always_ff @(posedge i_clk) begin
    if (hist_we && !i_rst) begin
      hist_q[wr_ptr_q] <= display_q;
    end
  end

  assign o_reseed     = reseed_q;
  assign o_step       = step_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_display    = display_q;
  assign o_hist_count = count_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// Self-checking bench for roll_sequencer with a short roll configuration.
// Cycle 0 is the cycle in which i_start is driven; outputs are sampled 1 time
// unit after each rising edge. Committed results are checked through a
// scoreboard queue filled when a roll is launched.
module tb_roll_sequencer;
  localparam int unsigned INIT_PERIOD = 8;
  localparam int unsigned MAX_STEPS   = 3;
  localparam int unsigned HIST_DEPTH  = 2;
  localparam int unsigned DATA_W      = 13;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned HCW         = $clog2(HIST_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, start, stop, prev;
  logic [DATA_W-1:0] value;
  logic              reseed, step, busy, done;
  logic [DATA_W-1:0] display;
  logic [HCW-1:0]    hist_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [DATA_W-1:0] sb_q [$];

  always #5 clk = ~clk;

  roll_sequencer #(
    .INIT_PERIOD(INIT_PERIOD),
    .MAX_STEPS  (MAX_STEPS),
    .HIST_DEPTH (HIST_DEPTH),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_previous  (prev),
    .i_value     (value),
    .o_reseed    (reseed),
    .o_step      (step),
    .o_busy      (busy),
    .o_done      (done),
    .o_display   (display),
    .o_hist_count(hist_count)
  );

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; prev = 1'b0; value = '0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy, reseed, step, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: busy/reseed/step/done=%b required 0000",
               {busy, reseed, step, done});
    end
    n_checks++;
    if (display !== '0) begin
      n_fail++; $display("FAIL reset_display: got %0d required 0", display);
    end
    n_checks++;
    if (hist_count !== '0) begin
      n_fail++; $display("FAIL reset_hist_count: got %0d required 0", hist_count);
    end
  endtask

  task automatic test_full_roll();
    logic [127:0] m_rs, m_st, m_bz, m_dn, m_dc, e_bz;
    logic [DATA_W-1:0] vals [3];
    logic [DATA_W-1:0] last, exp_v;
    int vi;
    vals = '{13'd5, 13'd9, 13'd12};
    m_rs = '0; m_st = '0; m_bz = '0; m_dn = '0; m_dc = '0; e_bz = '0; vi = 0;
    do_reset();
    last = display;
    sb_q.push_back(13'd12);
    start = 1'b1; cyc = 0;
    for (int c = 1; c <= 45; c++) begin
      adv();
      start = 1'b0;
      if (reseed) m_rs[cyc] = 1'b1;
      if (busy) m_bz[cyc] = 1'b1;
      if (display !== last) begin m_dc[cyc] = 1'b1; last = display; end
      if (done) begin
        m_dn[cyc] = 1'b1;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL sb_done: o_done at cycle %0d with nothing expected", cyc);
        end else begin
          exp_v = sb_q.pop_front();
          if (display !== exp_v) begin
            n_fail++; $display("FAIL sb_result: display=%0d required %0d", display, exp_v);
          end
        end
      end
      if (step) begin
        m_st[cyc] = 1'b1;
        if (vi < 3) value = vals[vi];
        vi++;
      end
    end
    for (int c = 1; c <= 34; c++) e_bz[c] = 1'b1;
    n_checks++;
    if (m_rs !== (128'd1 << 1)) begin
      n_fail++; $display("FAIL roll_reseed: cycles mask %h required %h", m_rs, 128'd1 << 1);
    end
    n_checks++;
    if (m_st !== ((128'd1 << 9) | (128'd1 << 20) | (128'd1 << 32))) begin
      n_fail++; $display("FAIL roll_step: cycles mask %h required steps at 9,20,32", m_st);
    end
    n_checks++;
    if (m_dc !== ((128'd1 << 11) | (128'd1 << 22) | (128'd1 << 34))) begin
      n_fail++; $display("FAIL roll_display_update: mask %h required 11,22,34", m_dc);
    end
    n_checks++;
    if (m_dn !== (128'd1 << 34)) begin
      n_fail++; $display("FAIL roll_done: mask %h required cycle 34", m_dn);
    end
    n_checks++;
    if (m_bz !== e_bz) begin
      n_fail++; $display("FAIL roll_busy: mask %h required %h", m_bz, e_bz);
    end
    n_checks++;
    if (display !== 13'd12 || hist_count !== HCW'(1)) begin
      n_fail++;
      $display("FAIL roll_result: display=%0d count=%0d required 12 and 1", display, hist_count);
    end
  endtask

  task automatic test_stop();
    logic [127:0] m_st, m_dn;
    logic [DATA_W-1:0] exp_v;
    m_st = '0; m_dn = '0;
    do_reset();
    sb_q.push_back('0);
    start = 1'b1; cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      adv();
      start = 1'b0;
      stop = (cyc == 4);
      if (step) begin m_st[cyc] = 1'b1; value = 13'd77; end
      if (done) begin
        m_dn[cyc] = 1'b1;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL sb_done: o_done at cycle %0d with nothing expected", cyc);
        end else begin
          exp_v = sb_q.pop_front();
          if (display !== exp_v) begin
            n_fail++; $display("FAIL sb_result: display=%0d required %0d", display, exp_v);
          end
        end
      end
    end
    stop = 1'b0;
    n_checks++;
    if (m_st !== '0) begin
      n_fail++; $display("FAIL stop_no_step: step mask %h required 0", m_st);
    end
    n_checks++;
    if (m_dn !== (128'd1 << 9)) begin
      n_fail++; $display("FAIL stop_done: mask %h required cycle 9", m_dn);
    end
    n_checks++;
    if (display !== '0 || hist_count !== HCW'(1) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_result: display=%0d count=%0d busy=%b required 0,1,0",
               display, hist_count, busy);
    end
  endtask

  task automatic test_history();
    logic [DATA_W-1:0] finals [3];
    logic [DATA_W-1:0] exp_v;
    int vi;
    finals = '{13'd12, 13'd7, 13'd3};
    do_reset();
    for (int r = 0; r < 3; r++) begin
      sb_q.push_back(finals[r]);
      vi = 0;
      start = 1'b1; cyc = 0;
      for (int c = 1; c <= 40; c++) begin
        adv();
        start = 1'b0;
        if (step) begin
          value = (vi == 2) ? finals[r] : DATA_W'(50 + r * 10 + vi);
          vi++;
        end
        if (done) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++; $display("FAIL sb_done: o_done at cycle %0d with nothing expected", cyc);
          end else begin
            exp_v = sb_q.pop_front();
            if (display !== exp_v) begin
              n_fail++; $display("FAIL sb_result: display=%0d required %0d", display, exp_v);
            end
          end
        end
      end
    end
    n_checks++;
    if (hist_count !== HCW'(2) || display !== 13'd3) begin
      n_fail++;
      $display("FAIL hist_saturate: count=%0d display=%0d required 2 and 3", hist_count, display);
    end
    prev = 1'b1;
    adv();
    prev = 1'b0;
    n_checks++;
    if (display !== 13'd7) begin
      n_fail++; $display("FAIL hist_prev1: display=%0d required 7", display);
    end
    prev = 1'b1;
    adv();
    prev = 1'b0;
    adv();
    n_checks++;
    if (display !== 13'd7) begin
      n_fail++; $display("FAIL hist_prev_oldest: display=%0d required 7", display);
    end
  endtask

  task automatic test_restart();
    logic [127:0] m_rs, m_st, m_dn, m_bz, e_bz;
    logic [DATA_W-1:0] exp_v;
    int vi;
    m_rs = '0; m_st = '0; m_dn = '0; m_bz = '0; e_bz = '0; vi = 0;
    do_reset();
    start = 1'b1; cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      adv();
      start = (cyc == 15);
      if (cyc == 15) sb_q.push_back(13'd103);
      if (reseed) m_rs[cyc] = 1'b1;
      if (busy) m_bz[cyc] = 1'b1;
      if (step) begin m_st[cyc] = 1'b1; value = DATA_W'(100 + vi); vi++; end
      if (done) begin
        m_dn[cyc] = 1'b1;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL sb_done: o_done at cycle %0d with nothing expected", cyc);
        end else begin
          exp_v = sb_q.pop_front();
          if (display !== exp_v) begin
            n_fail++; $display("FAIL sb_result: display=%0d required %0d", display, exp_v);
          end
        end
      end
    end
    for (int c = 1; c <= 49; c++) e_bz[c] = 1'b1;
    n_checks++;
    if (m_rs !== ((128'd1 << 1) | (128'd1 << 16))) begin
      n_fail++; $display("FAIL restart_reseed: mask %h required cycles 1,16", m_rs);
    end
    n_checks++;
    if (m_st !== ((128'd1 << 9) | (128'd1 << 24) | (128'd1 << 35) | (128'd1 << 47))) begin
      n_fail++; $display("FAIL restart_step: mask %h required 9,24,35,47", m_st);
    end
    n_checks++;
    if (m_dn !== (128'd1 << 49) || m_bz !== e_bz) begin
      n_fail++; $display("FAIL restart_done_busy: done %h busy %h required done at 49", m_dn, m_bz);
    end
  endtask

  task automatic test_start_in_commit();
    logic [127:0] m_rs, m_dn, m_bz, e_bz;
    logic [DATA_W-1:0] exp_v;
    int vi;
    m_rs = '0; m_dn = '0; m_bz = '0; e_bz = '0; vi = 0;
    sb_q.push_back(13'd202);
    start = 1'b1; cyc = 0;
    for (int c = 1; c <= 75; c++) begin
      adv();
      start = (cyc == 34);
      if (cyc == 34) sb_q.push_back(13'd205);
      if (reseed) m_rs[cyc] = 1'b1;
      if (busy) m_bz[cyc] = 1'b1;
      if (step) begin value = DATA_W'(200 + vi); vi++; end
      if (done) begin
        m_dn[cyc] = 1'b1;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL sb_done: o_done at cycle %0d with nothing expected", cyc);
        end else begin
          exp_v = sb_q.pop_front();
          if (display !== exp_v) begin
            n_fail++; $display("FAIL sb_result: display=%0d required %0d", display, exp_v);
          end
        end
      end
    end
    for (int c = 1; c <= 68; c++) e_bz[c] = 1'b1;
    n_checks++;
    if (m_rs !== ((128'd1 << 1) | (128'd1 << 35))) begin
      n_fail++; $display("FAIL commit_restart_reseed: mask %h required cycles 1,35", m_rs);
    end
    n_checks++;
    if (m_dn !== ((128'd1 << 34) | (128'd1 << 68)) || m_bz !== e_bz) begin
      n_fail++;
      $display("FAIL commit_restart_done_busy: done %h busy %h required done 34,68", m_dn, m_bz);
    end
  endtask

  task automatic test_reset_midroll();
    logic [127:0] m_st, m_dn;
    m_st = '0; m_dn = '0;
    start = 1'b1; cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      adv();
      start = 1'b0;
      rst = (cyc == 21);
      if (step) begin m_st[cyc] = 1'b1; value = 13'd300; end
      if (done) m_dn[cyc] = 1'b1;
      if (cyc == 21) begin
        n_checks++;
        if (hist_count !== HCW'(2) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL midroll_pre: count=%0d busy=%b required 2 and 1", hist_count, busy);
        end
      end
      if (cyc == 22) begin
        n_checks++;
        if (busy !== 1'b0 || display !== '0 || hist_count !== '0) begin
          n_fail++;
          $display("FAIL midroll_reset: busy=%b display=%0d count=%0d required 0,0,0",
                   busy, display, hist_count);
        end
      end
    end
    rst = 1'b0;
    n_checks++;
    if (m_st !== ((128'd1 << 9) | (128'd1 << 20)) || m_dn !== '0) begin
      n_fail++;
      $display("FAIL midroll_quiet: step %h done %h required steps 9,20 only, no done", m_st, m_dn);
    end
  endtask

  initial begin
    test_reset();
    test_full_roll();
    test_stop();
    test_history();
    test_restart();
    test_start_in_commit();
    test_reset_midroll();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d results never committed", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/roll_sequencer.md
Name: roll_sequencer

Overview:
- Control block for the LFSR dice/random-number datapath.
- Sequences a roll: reseed pulse, step pulses at a geometrically growing period (slow-down effect), capture of each new value, and commit of the final result.
- Owns a circular history of committed results so the "previous" button can page back through them.
- Sits between the debounced button pulses and the random datapath; drives the 7-seg display value.

Parameters:
- INIT_PERIOD, 1000000, cycles between reseed and first step (must be >= 1)
- MAX_STEPS, 27, number of steps per full roll (must be >= 1)
- HIST_DEPTH, 4, committed-result history entries (>= 2)
- DATA_W, 13, result width
- CNT_W, 32, period/tick counter width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse: begin or restart a roll
- i_stop  in  1  one-cycle pulse: end the roll early
- i_previous  in  1  one-cycle pulse: show the next-older history entry
- i_value  in  DATA_W  datapath result; updates on the edge that ends an o_step cycle
- o_reseed  out  1  one-cycle pulse: datapath reloads its seed
- o_step  out  1  one-cycle pulse: datapath advances one LFSR step
- o_busy  out  1  high while a roll is in progress
- o_done  out  1  one-cycle pulse: result committed
- o_display  out  DATA_W  value to show
- o_hist_count  out  $clog2(HIST_DEPTH+1)  valid history entries

Behaviour:
- Interface: one clock, i_clk; reset is synchronous and active-high on i_rst.
- All outputs are registered.
- Reset (any state, including mid-roll):
  - state=IDLE
  - all pulse outputs 0, o_busy=0
  - o_display=0, o_hist_count=0, view index=0, stop_pending=0
- States:
  - IDLE, RUN, STEP, CAPTURE, COMMIT.
  - o_busy=1 in every state except IDLE.
- IDLE:
  - i_start -> RUN with period=INIT_PERIOD, tick=0, steps=MAX_STEPS, stop_pending=0.
  - o_reseed=1 during the first RUN cycle.
- RUN:
  - tick increments each cycle.
  - When tick==period-1: go to STEP, or to COMMIT if stop_pending.
  - RUN therefore lasts exactly period cycles.
- STEP:
  - o_step=1 for exactly one cycle.
  - Next state: CAPTURE.
- CAPTURE:
  - o_display<=i_value; steps<=steps-1; period<=period+(period>>3), saturating at 2^CNT_W-1.
  - If new steps==0 or stop_pending: go to COMMIT.
  - Otherwise go to RUN with tick=0.
- COMMIT:
  - Push o_display into history; when full, overwrite the oldest entry (count saturates at HIST_DEPTH).
  - view index=0, o_done=1, go to IDLE.
- i_stop:
  - Ignored in IDLE and COMMIT.
  - In RUN/STEP/CAPTURE it sets stop_pending.
  - The roll ends at the next boundary without any further o_step.
- i_start while busy (RUN/STEP/CAPTURE) restarts the roll:
  - reload as from IDLE, o_reseed pulse, no commit.
  - i_start overrides i_stop in the same cycle.
- i_start in COMMIT: the commit completes, then go to RUN with reload and reseed (no IDLE cycle).
- i_previous:
  - Acts only in IDLE, and only when i_start is low.
  - If view+1 < o_hist_count: view++ and o_display <= hist[view], effective next cycle (view 0 = newest).
  - Otherwise no change (saturates at the oldest entry; no effect with 0 or 1 entries).
  - Ignored while busy.
- History is preserved across rolls and cleared only by i_rst.

Test Plan:
- Params INIT_PERIOD=8, MAX_STEPS=3, HIST_DEPTH=2; i_start at cycle 0 ->
  - o_reseed at cycle 1
  - o_step at cycles 9, 20, 32
  - o_display updates at cycles 11, 22, 34
  - o_done at 34, o_busy high for cycles 1..34
- Same params, i_value =5,9,12 for the three steps -> o_display=12 after done, o_hist_count=1.
- i_stop at cycle 4 ->
  - no o_step at all
  - COMMIT in cycle 9, o_done=1 at 9
  - o_display unchanged (0); history pushes 0.
- Three full rolls with final values 12, 7, 3 ->
  - o_hist_count=2 (saturated)
  - one i_previous -> o_display=7; second i_previous -> stays 7.
- i_start again at cycle 15 of a roll ->
  - second o_reseed, no o_done
  - steps reload, next o_step 9 cycles after the restart pulse.
- i_rst at cycle 21 mid-roll ->
  - next cycle: o_busy=0, o_display=0, o_hist_count=0
  - no o_step or o_done afterwards.
